// File: rtl/npc_mem_pkg.sv
// Shared types and constants for the NPC memory responder.
package npc_mem_pkg;

   localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8000_0000;
   localparam int unsigned CNT_W             = 4;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {
      IDLE,
      R_WAIT,
      R_RESP,
      W_WAIT,
      W_RESP
   } state_e;

endpackage

// File: rtl/npc_mem_array.sv
// Single-port word RAM with a registered read port and per-byte write enables.
module npc_mem_array #(
   parameter int unsigned DEPTH_WORDS = 4096,
   parameter int unsigned AW          = 12
) (
   input  logic          clk,
   input  logic          i_re,
   input  logic [3:0]    i_we,
   input  logic [AW-1:0] i_addr,
   input  logic [31:0]   i_wdata,
   output logic [31:0]   o_rdata
);

   logic [31:0] r_mem [DEPTH_WORDS];
   logic [31:0] r_rdata;

   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (i_we[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
      if (i_re) r_rdata <= r_mem[i_addr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/npc_mem_responder.sv
// Valid/ready memory responder: one read or write in flight, fixed response latency,
// backed by npc_mem_array at BASE_ADDR.
module npc_mem_responder
   import npc_mem_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
   parameter int unsigned DEPTH_WORDS = 4096,
   parameter int unsigned LATENCY     = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] araddr,
   input  logic        arvalid,
   output logic        arready,
   output logic [31:0] rdata,
   output logic [1:0]  rresp,
   output logic        rvalid,
   input  logic        rready,
   input  logic [31:0] awaddr,
   input  logic        awvalid,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   input  logic        wvalid,
   output logic        awready,
   output logic        wready,
   output logic [1:0]  bresp,
   output logic        bvalid,
   input  logic        bready
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);

   state_e           r_state, w_next;
   logic [CNT_W-1:0] r_cnt, w_cnt_next;
   logic [31:0]      r_addr, r_wdata;
   logic [3:0]       r_wstrb;
   logic             r_err;

   logic             w_wr_pend, w_wr_acc, w_rd_acc, w_enter_r, w_enter_w;
   logic [31:0]      w_cur_addr, w_cur_wdata;
   logic [3:0]       w_cur_wstrb;
   logic [32:0]      w_off;
   logic             w_in_range;
   logic [AW-1:0]    w_idx;
   logic             w_ram_re;
   logic [3:0]       w_ram_we;
   logic [31:0]      w_ram_q;
   logic             w_unused;

   // A write needs address and data together; it takes priority over a read.
   assign w_wr_pend = awvalid && wvalid;
   assign w_wr_acc  = !reset && (r_state == IDLE) && w_wr_pend;
   assign w_rd_acc  = !reset && (r_state == IDLE) && arvalid && !w_wr_pend;
   assign arready   = !reset && (r_state == IDLE) && !w_wr_pend;
   assign awready   = w_wr_acc;
   assign wready    = w_wr_acc;

   // Live request in IDLE (zero-latency path), latched request otherwise.
   always_comb begin
      w_cur_addr  = r_addr;
      w_cur_wdata = r_wdata;
      w_cur_wstrb = r_wstrb;
      if (r_state == IDLE) begin
         w_cur_addr  = w_wr_pend ? awaddr : araddr;
         w_cur_wdata = wdata;
         w_cur_wstrb = wstrb;
      end
   end

   // 33-bit offset so addresses below BASE_ADDR show up as a borrow, not a wrap.
   assign w_off      = 33'(w_cur_addr) - 33'(BASE_ADDR);
   assign w_in_range = !w_off[32] && (w_off[31:2] < 30'(DEPTH_WORDS));
   assign w_idx      = w_off[AW+1:2];
   assign w_unused   = ^w_off[1:0];

   always_comb begin
      w_next     = r_state;
      w_cnt_next = r_cnt;
      case (r_state)
         IDLE: begin
            if (w_wr_acc) begin
               w_next     = (LATENCY == 0) ? W_RESP : W_WAIT;
               w_cnt_next = CNT_W'(LATENCY);
            end else if (w_rd_acc) begin
               w_next     = (LATENCY == 0) ? R_RESP : R_WAIT;
               w_cnt_next = CNT_W'(LATENCY);
            end
         end
         R_WAIT, W_WAIT: begin
            if (r_cnt <= CNT_W'(1)) begin
               w_next     = (r_state == R_WAIT) ? R_RESP : W_RESP;
               w_cnt_next = '0;
            end else begin
               w_cnt_next = r_cnt - CNT_W'(1);
            end
         end
         R_RESP: if (rready) w_next = IDLE;
         W_RESP: if (bready) w_next = IDLE;
         default: w_next = IDLE;
      endcase
      if (reset) begin
         w_next     = IDLE;
         w_cnt_next = '0;
      end
   end

   assign w_enter_r = (w_next == R_RESP) && (r_state != R_RESP);
   assign w_enter_w = (w_next == W_RESP) && (r_state != W_RESP);
   assign w_ram_re  = w_enter_r && w_in_range;
   assign w_ram_we  = (w_enter_w && w_in_range) ? w_cur_wstrb : 4'b0000;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt_next;
         if (w_enter_r || w_enter_w) r_err <= !w_in_range;
      end
   end

   // Request capture; only meaningful while a transaction is in flight.
   always_ff @(posedge clk) begin
      if (w_wr_acc || w_rd_acc) begin
         r_addr  <= w_cur_addr;
         r_wdata <= wdata;
         r_wstrb <= wstrb;
      end
   end

   npc_mem_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_array (
      .clk     (clk),
      .i_re    (w_ram_re),
      .i_we    (w_ram_we),
      .i_addr  (w_idx),
      .i_wdata (w_cur_wdata),
      .o_rdata (w_ram_q)
   );

   assign rvalid = (r_state == R_RESP);
   assign bvalid = (r_state == W_RESP);
   assign rdata  = (rvalid && !r_err) ? w_ram_q : 32'h0;
   assign rresp  = (rvalid && r_err) ? RESP_SLVERR : RESP_OKAY;
   assign bresp  = (bvalid && r_err) ? RESP_SLVERR : RESP_OKAY;

endmodule

// File: tb/tb_npc_mem_responder.sv
// Bench for npc_mem_responder: directed table, corner sequences, random traffic vs a word-map model.
module tb_npc_mem_responder;

   localparam longint unsigned BASE  = 64'h8000_0000;
   localparam longint unsigned DEPTH = 4096;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] araddr, awaddr, wdata;
   logic        arvalid, rready, awvalid, wvalid, bready;
   logic [3:0]  wstrb;
   logic        arready, rvalid, awready, wready, bvalid;
   logic [31:0] rdata;
   logic [1:0]  rresp, bresp;

   logic [31:0] z_araddr, z_awaddr, z_wdata;
   logic        z_arvalid, z_rready, z_awvalid, z_wvalid, z_bready;
   logic [3:0]  z_wstrb;
   logic        z_arready, z_rvalid, z_awready, z_wready, z_bvalid;
   logic [31:0] z_rdata;
   logic [1:0]  z_rresp, z_bresp;

   always #5 clk = ~clk;

   npc_mem_responder #(.BASE_ADDR(32'h8000_0000), .DEPTH_WORDS(4096), .LATENCY(2)) u_dut (
      .clk(clk), .reset(reset),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
      .awaddr(awaddr), .awvalid(awvalid), .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid),
      .awready(awready), .wready(wready), .bresp(bresp), .bvalid(bvalid), .bready(bready));

   npc_mem_responder #(.BASE_ADDR(32'h8000_0000), .DEPTH_WORDS(4096), .LATENCY(0)) u_dut0 (
      .clk(clk), .reset(reset),
      .araddr(z_araddr), .arvalid(z_arvalid), .arready(z_arready),
      .rdata(z_rdata), .rresp(z_rresp), .rvalid(z_rvalid), .rready(z_rready),
      .awaddr(z_awaddr), .awvalid(z_awvalid), .wdata(z_wdata), .wstrb(z_wstrb), .wvalid(z_wvalid),
      .awready(z_awready), .wready(z_wready), .bresp(z_bresp), .bvalid(z_bvalid), .bready(z_bready));

   int total = 0;
   int bad   = 0;

   logic [31:0] mem_m [int unsigned];
   int unsigned pool_in  [10] = '{0, 1, 2, 3, 4, 5, 8, 16, 1023, 4095};
   logic [31:0] pool_oor [5]  = '{32'h7FFF_FFFC, 32'h8000_4000, 32'h0000_0000, 32'hFFFF_FFFC, 32'h8000_4100};

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [31:0] exp_data;
      logic [1:0]  exp_resp;
   } vec_t;
   vec_t tbl [16];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // Reference model: a map of word index -> value, decoded with plain 64-bit arithmetic.
   function automatic bit m_in(input logic [31:0] a);
      longint unsigned x = 64'(a);
      return (x >= BASE) && (x < BASE + 4 * DEPTH);
   endfunction

   function automatic int unsigned m_idx(input logic [31:0] a);
      return 32'((64'(a) - BASE) >> 2);
   endfunction

   task automatic m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] w;
      if (m_in(a)) begin
         w = mem_m.exists(m_idx(a)) ? mem_m[m_idx(a)] : 32'h0;
         for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
         mem_m[m_idx(a)] = w;
      end
   endtask

   task automatic m_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
      d = 32'h0;
      r = 2'b10;
      if (m_in(a)) begin
         r = 2'b00;
         if (mem_m.exists(m_idx(a))) d = mem_m[m_idx(a)];
      end
   endtask

   // All transaction tasks start and end 1 time unit after a rising edge.
   task automatic do_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input int hold, output logic [1:0] resp, output int lat);
      int n = 0;
      awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = (hold == 0);
      #1;
      while (!awready && n < 20) begin @(posedge clk); #1; n++; end
      check("wr_accept", 32'(awready), 32'd1);
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      lat = 0;
      while (!bvalid && lat < 40) begin @(posedge clk); #1; lat++; end
      check("wr_bvalid", 32'(bvalid), 32'd1);
      resp = bresp;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check("wr_hold", {29'd0, bvalid, bresp}, {29'd0, 1'b1, resp});
      end
      bready = 1'b1;
      @(posedge clk); #1;
      check("wr_done", 32'(bvalid), 32'd0);
   endtask

   task automatic do_rd(input logic [31:0] a, input int hold,
                        output logic [31:0] d, output logic [1:0] resp, output int lat);
      int n = 0;
      araddr = a; arvalid = 1'b1; rready = (hold == 0);
      #1;
      while (!arready && n < 20) begin @(posedge clk); #1; n++; end
      check("rd_accept", 32'(arready), 32'd1);
      @(posedge clk); #1;
      arvalid = 1'b0;
      lat = 0;
      while (!rvalid && lat < 40) begin @(posedge clk); #1; lat++; end
      check("rd_rvalid", 32'(rvalid), 32'd1);
      d = rdata;
      resp = rresp;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check("rd_hold_data", rdata, d);
         check("rd_hold_flags", {29'd0, rvalid, rresp}, {29'd0, 1'b1, resp});
      end
      rready = 1'b1;
      @(posedge clk); #1;
      check("rd_done", 32'(rvalid), 32'd0);
   endtask

   initial begin
      logic [31:0] d, e, a;
      logic [1:0]  r, er;
      int          lat, n;

      tbl[0]  = '{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0,         2'b00};
      tbl[1]  = '{1'b0, 32'h8000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 2'b00};
      tbl[2]  = '{1'b1, 32'h8000_0020, 32'h1122_3344, 4'hF, 32'h0,         2'b00};
      tbl[3]  = '{1'b1, 32'h8000_0020, 32'h0000_00AA, 4'h1, 32'h0,         2'b00};
      tbl[4]  = '{1'b1, 32'h8000_0020, 32'hBB00_0000, 4'h8, 32'h0,         2'b00};
      tbl[5]  = '{1'b0, 32'h8000_0020, 32'h0,         4'h0, 32'hBB22_33AA, 2'b00};
      tbl[6]  = '{1'b0, 32'h7FFF_FFFC, 32'h0,         4'h0, 32'h0,         2'b10};
      tbl[7]  = '{1'b0, 32'h8000_4000, 32'h0,         4'h0, 32'h0,         2'b10};
      tbl[8]  = '{1'b1, 32'h8000_3FFC, 32'h5555_5555, 4'hF, 32'h0,         2'b00};
      tbl[9]  = '{1'b1, 32'h8000_4000, 32'hCAFE_F00D, 4'hF, 32'h0,         2'b10};
      tbl[10] = '{1'b0, 32'h8000_3FFC, 32'h0,         4'h0, 32'h5555_5555, 2'b00};
      tbl[11] = '{1'b1, 32'h7FFF_FFFC, 32'h0000_0001, 4'hF, 32'h0,         2'b10};
      tbl[12] = '{1'b1, 32'h8000_0000, 32'h0BAD_F00D, 4'hF, 32'h0,         2'b00};
      tbl[13] = '{1'b0, 32'h8000_0000, 32'h0,         4'h0, 32'h0BAD_F00D, 2'b00};
      tbl[14] = '{1'b1, 32'h8000_0010, 32'h0000_0000, 4'h0, 32'h0,         2'b00};
      tbl[15] = '{1'b0, 32'h8000_0013, 32'h0,         4'h0, 32'hDEAD_BEEF, 2'b00};

      reset = 1'b1;
      araddr = '0; arvalid = 1'b0; rready = 1'b0;
      awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
      z_araddr = '0; z_arvalid = 1'b0; z_rready = 1'b0;
      z_awaddr = '0; z_awvalid = 1'b0; z_wdata = '0; z_wstrb = '0; z_wvalid = 1'b0; z_bready = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", {29'd0, arready, awready, wready}, 32'd0);
      check("rst_valid", {30'd0, rvalid, bvalid}, 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_resp", {28'd0, rresp, bresp}, 32'd0);
      check("rst0_flags", {27'd0, z_arready, z_awready, z_wready, z_rvalid, z_bvalid}, 32'd0);
      reset = 1'b0;

      // Directed table, including byte masks and both range edges.
      for (int i = 0; i < 16; i++) begin
         if (tbl[i].wr) begin
            do_wr(tbl[i].addr, tbl[i].data, tbl[i].strb, 0, r, lat);
            m_write(tbl[i].addr, tbl[i].data, tbl[i].strb);
            check($sformatf("tbl%0d_bresp", i), 32'(r), 32'(tbl[i].exp_resp));
         end else begin
            do_rd(tbl[i].addr, 0, d, r, lat);
            check($sformatf("tbl%0d_rdata", i), d, tbl[i].exp_data);
            check($sformatf("tbl%0d_rresp", i), 32'(r), 32'(tbl[i].exp_resp));
         end
         check($sformatf("tbl%0d_lat", i), 32'(lat), 32'd2);
      end

      // Read backpressure: response held, new read ignored, then accepted next cycle.
      araddr = 32'h8000_0010; arvalid = 1'b1; rready = 1'b0;
      #1;
      check("bp_arready_idle", 32'(arready), 32'd1);
      @(posedge clk); #1;
      araddr = 32'h8000_0020;
      n = 0;
      while (!rvalid && n < 10) begin @(posedge clk); #1; n++; end
      check("bp_lat", 32'(n), 32'd2);
      for (int i = 0; i < 5; i++) begin
         check("bp_hold_rvalid", 32'(rvalid), 32'd1);
         check("bp_hold_rdata", rdata, 32'hDEAD_BEEF);
         check("bp_hold_arready", 32'(arready), 32'd0);
         @(posedge clk); #1;
      end
      rready = 1'b1;
      @(posedge clk); #1;
      check("bp_done", 32'(rvalid), 32'd0);
      check("bp_next_arready", 32'(arready), 32'd1);
      @(posedge clk); #1;
      arvalid = 1'b0;
      n = 0;
      while (!rvalid && n < 10) begin @(posedge clk); #1; n++; end
      check("bp_next_rdata", rdata, 32'hBB22_33AA);
      @(posedge clk); #1;

      // Simultaneous read and write: write first, read then sees the new data.
      araddr = 32'h8000_0040; arvalid = 1'b1; rready = 1'b1;
      awaddr = 32'h8000_0040; wdata = 32'h600D_CAFE; wstrb = 4'hF;
      awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
      #1;
      check("sim_awready", {30'd0, awready, wready}, 32'd3);
      check("sim_arready", 32'(arready), 32'd0);
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      m_write(32'h8000_0040, 32'h600D_CAFE, 4'hF);
      check("sim_busy_arready", 32'(arready), 32'd0);
      n = 0;
      while (!bvalid && n < 10) begin @(posedge clk); #1; n++; end
      check("sim_bresp", {29'd0, bvalid, bresp}, 32'h4);
      @(posedge clk); #1;
      check("sim_rd_arready", 32'(arready), 32'd1);
      @(posedge clk); #1;
      arvalid = 1'b0;
      n = 0;
      while (!rvalid && n < 10) begin @(posedge clk); #1; n++; end
      check("sim_rdata", rdata, 32'h600D_CAFE);
      @(posedge clk); #1;

      // Reset while a write waits: no response, array untouched.
      awaddr = 32'h8000_0000; wdata = 32'h1234_5678; wstrb = 4'hF;
      awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
      #1;
      check("rstw_accept", 32'(awready), 32'd1);
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      check("rstw_flags", {27'd0, arready, awready, wready, rvalid, bvalid}, 32'd0);
      check("rstw_data", {28'd0, rresp, bresp} | rdata, 32'd0);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("rstw_no_bvalid", 32'(bvalid), 32'd0);
      end
      do_rd(32'h8000_0000, 0, d, r, lat);
      check("rstw_prior", d, 32'h0BAD_F00D);

      // Zero-latency build: valid one cycle after acceptance.
      z_awaddr = 32'h8000_0008; z_wdata = 32'hA5A5_5A5A; z_wstrb = 4'hF;
      z_awvalid = 1'b1; z_wvalid = 1'b1; z_bready = 1'b0;
      #1;
      check("l0_awready", 32'(z_awready), 32'd1);
      @(posedge clk); #1;
      z_awvalid = 1'b0; z_wvalid = 1'b0;
      check("l0_bvalid", {29'd0, z_bvalid, z_bresp}, 32'h4);
      z_bready = 1'b1;
      @(posedge clk); #1;
      check("l0_bdone", 32'(z_bvalid), 32'd0);
      z_araddr = 32'h8000_0008; z_arvalid = 1'b1; z_rready = 1'b1;
      #1;
      check("l0_arready", 32'(z_arready), 32'd1);
      @(posedge clk); #1;
      z_arvalid = 1'b0;
      check("l0_rvalid", {29'd0, z_rvalid, z_rresp}, 32'h4);
      check("l0_rdata", z_rdata, 32'hA5A5_5A5A);
      @(posedge clk); #1;
      check("l0_rdone", 32'(z_rvalid), 32'd0);

      // Random traffic against the model.
      for (int i = 0; i < 10; i++) begin
         a = 32'(BASE) + 32'(pool_in[i]) * 4;
         d = $urandom;
         do_wr(a, d, 4'hF, 0, r, lat);
         m_write(a, d, 4'hF);
         check("pre_bresp", 32'(r), 32'd0);
      end
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 4) == 0) a = pool_oor[$urandom_range(0, 4)];
         else a = 32'(BASE) + 32'(pool_in[$urandom_range(0, 9)]) * 4;
         a[1:0] = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 1) begin
            d = $urandom;
            do_wr(a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 3), r, lat);
            m_write(a, d, wstrb);
            er = m_in(a) ? 2'b00 : 2'b10;
            check("rnd_bresp", 32'(r), 32'(er));
         end else begin
            do_rd(a, $urandom_range(0, 3), d, r, lat);
            m_read(a, e, er);
            check("rnd_rdata", d, e);
            check("rnd_rresp", 32'(r), 32'(er));
         end
         check("rnd_lat", 32'(lat), 32'd2);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule
